// File: rtl/gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker
//
// Exhaustive truth-table sweeper/checker for an N_IN-input complex gate.
// The block drives every input combination onto a gate under test, in binary
// ascending order. It compares the gate's output against a built-in golden
// model and reports pass/fail, a saturating error count and the first failing
// vector.
//
// Parameters
//   N_IN   : gate input count, legal range 2..16
//   MODE   : golden function, 0=OAI, 1=AOI, 2=NAND, 3=NOR
//   SETTLE : cycles each vector is held before it is sampled, legal 1..255
//   ERR_W  : error counter width
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   start          in   one-cycle pulse, honoured only in IDLE or DONE
//   dut_y          in   gate output, combinational from stim
//   stim           out  vector driven to the gate (stim[N_IN-1] is operand a)
//   busy           out  high while a sweep is running (APPLY/CHECK)
//   done           out  high once the sweep result is final
//   pass           out  valid with done, equals (err_cnt == 0)
//   err_cnt        out  mismatch count, saturates at all-ones
//   first_fail_vld out  set on the first mismatch of the sweep
//   first_fail_vec out  stim value at the first mismatch
//
// Build option
//   SWEEP_STOP_ON_FAIL_EN : when defined, the first mismatch ends the sweep.
//                           stim then holds the failing vector. When
//                           undefined, the full sweep always completes.
// ---------------------------------------------------------------------------
module gate_sweep_checker #(
    parameter int N_IN   = 3,
    parameter int MODE   = 0,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dut_y,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              first_fail_vld,
    output logic [N_IN-1:0]   first_fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [N_IN-1:0]    r_stim;
    logic [7:0]         r_settle_cnt;
    logic [ERR_W-1:0]   r_err_cnt;
    logic               r_done;
    logic               r_pass;
    logic               r_first_fail_vld;
    logic [N_IN-1:0]    r_first_fail_vec;

    logic               w_golden;
    logic               w_mismatch;
    logic               w_settled;
    logic               w_stim_last;
    logic               w_busy;

    // Golden model. x[0] is the lone operand of OAI/AOI. The upper bits form
    // the OR/AND group, so for N_IN=3, OAI is ~((a|b)&c).
    generate
        if (MODE == 0) begin : g_oai
            assign w_golden = ~((|r_stim[N_IN-1:1]) & r_stim[0]);
        end else if (MODE == 1) begin : g_aoi
            assign w_golden = ~((&r_stim[N_IN-1:1]) | r_stim[0]);
        end else if (MODE == 2) begin : g_nand
            assign w_golden = ~(&r_stim);
        end else begin : g_nor
            assign w_golden = ~(|r_stim);
        end
    endgenerate

    // Case-inequality so an X/Z on dut_y counts as a mismatch in simulation.
    // Synthesis treats it as an ordinary inequality.
    assign w_mismatch  = (dut_y !== w_golden);
    assign w_settled   = (r_settle_cnt == SETTLE_LAST);
    assign w_stim_last = &r_stim;

    // Next-state and decoded outputs.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_APPLY;
                end
            end
            S_APPLY: begin
                w_busy = 1'b1;
                if (w_settled) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_busy = 1'b1;
`ifdef SWEEP_STOP_ON_FAIL_EN
                if (w_mismatch || w_stim_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_APPLY;
                end
`else
                if (w_stim_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_APPLY;
                end
`endif
            end
            S_DONE: begin
                if (start) begin
                    w_state_next = S_APPLY;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register and sweep datapath.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_stim           <= '0;
            r_settle_cnt     <= '0;
            r_err_cnt        <= '0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_first_fail_vld <= 1'b0;
            r_first_fail_vec <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_stim           <= '0;
                        r_settle_cnt     <= '0;
                        r_err_cnt        <= '0;
                        r_done           <= 1'b0;
                        r_pass           <= 1'b0;
                        r_first_fail_vld <= 1'b0;
                        r_first_fail_vec <= '0;
                    end else if (r_state == S_DONE) begin
                        // done/pass are registered one edge after DONE is
                        // entered. This lets pass see the final CHECK result.
                        r_done <= 1'b1;
                        r_pass <= (r_err_cnt == '0);
                    end
                end
                S_APPLY: begin
                    r_settle_cnt <= w_settled ? 8'd0 : r_settle_cnt + 8'd1;
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_cnt != '1) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        if (!r_first_fail_vld) begin
                            r_first_fail_vld <= 1'b1;
                            r_first_fail_vec <= r_stim;
                        end
                    end
                    // stim only advances when another vector follows, so it
                    // never wraps and holds the last checked vector in DONE.
                    if (w_state_next == S_APPLY) begin
                        r_stim <= r_stim + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stim           = r_stim;
    assign busy           = w_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = r_err_cnt;
    assign first_fail_vld = r_first_fail_vld;
    assign first_fail_vec = r_first_fail_vec;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_checker
//
// Three checker instances, each driven by a behavioural gate response:
//   0: N_IN=3 MODE=0 (OAI21) SETTLE=1 ERR_W=8
//   1: N_IN=3 MODE=0         SETTLE=1 ERR_W=2  (saturation)
//   2: N_IN=4 MODE=2 (NAND4) SETTLE=3 ERR_W=8
// The gate response is the bench's own golden function with an injected fault:
// ideal, stuck-at-0, stuck-at-1, or XOR with a per-vector flip mask.
// A sweep's expected result is computed and queued when start is driven. It is
// popped and compared when done rises.
// ---------------------------------------------------------------------------
module tb_gate_sweep_checker;

    localparam int P_N[3]      = '{3, 3, 4};
    localparam int P_MODE[3]   = '{0, 0, 2};
    localparam int P_SETTLE[3] = '{1, 1, 3};
    localparam int P_ERRW[3]   = '{8, 2, 8};
`ifdef SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    typedef struct {
        int done_edge;
        int err;
        int pass;
        int ffv;
        int ffvec;
        int stim;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v = '0;
    logic [2:0]  dut_y_v;
    logic [2:0]  busy_v, done_v, pass_v, ffv_v;
    logic [2:0]  stim0, stim1, ffvec0, ffvec1;
    logic [3:0]  stim2, ffvec2;
    logic [7:0]  err0, err2;
    logic [1:0]  err1;
    logic [15:0] stim_v[3], err_v[3], ffvec_v[3];

    int          fault[3] = '{0, 0, 0};
    logic [15:0] mask[3]  = '{16'h0, 16'h0, 16'h0};

    always #5 clk = ~clk;

    function automatic bit golden(input int n, input int mode, input int v);
        bit or_hi, and_hi, or_all, and_all;
        or_hi  = 1'b0;
        and_hi = 1'b1;
        for (int i = 1; i < n; i++) begin
            or_hi  = or_hi  | v[i];
            and_hi = and_hi & v[i];
        end
        or_all  = or_hi  | v[0];
        and_all = and_hi & v[0];
        case (mode)
            0:       return ~(or_hi & v[0]);
            1:       return ~(and_hi | v[0]);
            2:       return ~and_all;
            default: return ~or_all;
        endcase
    endfunction

    function automatic bit resp(input int f, input logic [15:0] m,
                                input int n, input int mode, input int v);
        case (f)
            1:       return 1'b0;
            2:       return 1'b1;
            4:       return golden(n, mode, v) ^ m[v[3:0]];
            default: return golden(n, mode, v);
        endcase
    endfunction

    assign dut_y_v[0] = resp(fault[0], mask[0], 3, 0, int'(stim0));
    assign dut_y_v[1] = resp(fault[1], mask[1], 3, 0, int'(stim1));
    assign dut_y_v[2] = resp(fault[2], mask[2], 4, 2, int'(stim2));

    assign stim_v[0]  = 16'(stim0);
    assign stim_v[1]  = 16'(stim1);
    assign stim_v[2]  = 16'(stim2);
    assign err_v[0]   = 16'(err0);
    assign err_v[1]   = 16'(err1);
    assign err_v[2]   = 16'(err2);
    assign ffvec_v[0] = 16'(ffvec0);
    assign ffvec_v[1] = 16'(ffvec1);
    assign ffvec_v[2] = 16'(ffvec2);

    gate_sweep_checker #(.N_IN(3), .MODE(0), .SETTLE(1), .ERR_W(8)) u_oai (
        .clk(clk), .rst(rst), .start(start_v[0]), .dut_y(dut_y_v[0]),
        .stim(stim0), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_cnt(err0), .first_fail_vld(ffv_v[0]), .first_fail_vec(ffvec0)
    );

    gate_sweep_checker #(.N_IN(3), .MODE(0), .SETTLE(1), .ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start_v[1]), .dut_y(dut_y_v[1]),
        .stim(stim1), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_cnt(err1), .first_fail_vld(ffv_v[1]), .first_fail_vec(ffvec1)
    );

    gate_sweep_checker #(.N_IN(4), .MODE(2), .SETTLE(3), .ERR_W(8)) u_nand (
        .clk(clk), .rst(rst), .start(start_v[2]), .dut_y(dut_y_v[2]),
        .stim(stim2), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_cnt(err2), .first_fail_vld(ffv_v[2]), .first_fail_vec(ffvec2)
    );

    // Expected result of one sweep on instance idx with its current fault.
    function automatic exp_t compute_exp(input int idx);
        exp_t e;
        int   errs    = 0;
        int   sat     = (1 << P_ERRW[idx]) - 1;
        int   checked = 0;
        bit   mm;
        e.ffv   = 0;
        e.ffvec = 0;
        e.stim  = 0;
        for (int v = 0; v < (1 << P_N[idx]); v++) begin
            checked++;
            e.stim = v;
            mm = resp(fault[idx], mask[idx], P_N[idx], P_MODE[idx], v) !=
                 golden(P_N[idx], P_MODE[idx], v);
            if (mm) begin
                if (errs < sat) errs++;
                if (e.ffv == 0) begin
                    e.ffv   = 1;
                    e.ffvec = v;
                end
                if (STOP_EN) break;
            end
        end
        e.done_edge = checked * (P_SETTLE[idx] + 1) + 1;
        e.err       = errs;
        e.pass      = (errs == 0) ? 1 : 0;
        return e;
    endfunction

    // Starts a sweep on instance idx, optionally re-pulsing start at edges
    // pa/pb (counted from the edge that samples start), then waits for done
    // and compares against the queued expectation.
    task automatic run_sweep(input int idx, input string name,
                             input int pa, input int pb);
        exp_t e;
        int   edges;
        bit   got_done;
        sb_q.push_back(compute_exp(idx));
        @(posedge clk); #1;
        start_v[idx] = 1'b1;
        @(posedge clk); #1;
        edges = 0;
        start_v[idx] = ((pa == 1) || (pb == 1));
        n_cmp++;
        if (busy_v[idx] !== 1'b1 || done_v[idx] !== 1'b0) begin
            n_mis++;
            $display("FAIL %s launch: busy=%b done=%b, required busy=1 done=0",
                     name, busy_v[idx], done_v[idx]);
        end
        got_done = 1'b0;
        while (edges < 2000) begin
            @(posedge clk); #1;
            edges++;
            start_v[idx] = ((pa == edges + 1) || (pb == edges + 1));
            if (done_v[idx] === 1'b1) begin
                got_done = 1'b1;
                break;
            end
        end
        start_v[idx] = 1'b0;
        e = sb_q.pop_front();
        n_cmp++;
        if (!got_done) begin
            n_mis++;
            $display("FAIL %s timeout: done not seen in %0d edges, required at edge %0d",
                     name, edges, e.done_edge);
            return;
        end
        if (edges !== e.done_edge) begin
            n_mis++;
            $display("FAIL %s done_edge: got %0d, required %0d", name, edges, e.done_edge);
        end
        n_cmp++;
        if (err_v[idx] !== 16'(e.err)) begin
            n_mis++;
            $display("FAIL %s err_cnt: got %0d, required %0d", name, err_v[idx], e.err);
        end
        n_cmp++;
        if (pass_v[idx] !== e.pass[0]) begin
            n_mis++;
            $display("FAIL %s pass: got %b, required %0d", name, pass_v[idx], e.pass);
        end
        n_cmp++;
        if (ffv_v[idx] !== e.ffv[0]) begin
            n_mis++;
            $display("FAIL %s first_fail_vld: got %b, required %0d", name, ffv_v[idx], e.ffv);
        end
        n_cmp++;
        if (ffvec_v[idx] !== 16'(e.ffvec)) begin
            n_mis++;
            $display("FAIL %s first_fail_vec: got %0h, required %0h", name, ffvec_v[idx], e.ffvec);
        end
        n_cmp++;
        if (stim_v[idx] !== 16'(e.stim)) begin
            n_mis++;
            $display("FAIL %s stim: got %0h, required %0h", name, stim_v[idx], e.stim);
        end
        n_cmp++;
        if (busy_v[idx] !== 1'b0) begin
            n_mis++;
            $display("FAIL %s busy_at_done: got %b, required 0", name, busy_v[idx]);
        end
        // Outputs must hold while idle in DONE.
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (done_v[idx] !== 1'b1 || err_v[idx] !== 16'(e.err) || stim_v[idx] !== 16'(e.stim)) begin
            n_mis++;
            $display("FAIL %s hold: done=%b err=%0d stim=%0h, required 1/%0d/%0h",
                     name, done_v[idx], err_v[idx], stim_v[idx], e.err, e.stim);
        end
    endtask

    task automatic check_reset_values(input string name);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (stim_v[i] !== 16'h0 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 ||
                pass_v[i] !== 1'b0 || err_v[i] !== 16'h0 || ffv_v[i] !== 1'b0 ||
                ffvec_v[i] !== 16'h0) begin
                n_mis++;
                $display("FAIL %s inst%0d: stim=%0h busy=%b done=%b pass=%b err=%0d ffv=%b ffvec=%0h, required all zero",
                         name, i, stim_v[i], busy_v[i], done_v[i], pass_v[i],
                         err_v[i], ffv_v[i], ffvec_v[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        // start coincident with rst: rst wins.
        start_v = 3'b111;
        @(posedge clk); #1;
        start_v = 3'b000;
        check_reset_values("start_during_rst");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_values("idle_after_rst");
    endtask

    task automatic test_ideal_sweep();
        fault[0] = 0;
        run_sweep(0, "ideal_oai", -1, -1);
    endtask

    task automatic test_stuck_at_0();
        fault[0] = 1;
        run_sweep(0, "stuck0_oai", -1, -1);
    endtask

    task automatic test_back_to_back();
        // Restart straight from DONE with a different fault.
        fault[0] = 2;
        run_sweep(0, "b2b_stuck1_oai", -1, -1);
        fault[0] = 0;
        run_sweep(0, "b2b_ideal_oai", -1, -1);
    endtask

    task automatic test_reset_mid_sweep();
        fault[0] = 1;
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;          // edge 0 samples start
        start_v[0] = 1'b0;
        repeat (5) @(posedge clk);   // up to edge 5
        #1;
        rst = 1'b1;
        @(posedge clk); #1;          // edge 6 samples rst
        rst = 1'b0;
        check_reset_values("rst_mid_sweep");
        fault[0] = 0;
        run_sweep(0, "after_rst_ideal", -1, -1);
    endtask

    task automatic test_start_ignored();
        fault[0] = 0;
        run_sweep(0, "start_while_busy", 4, 9);
    endtask

    task automatic test_random_faults();
        for (int k = 0; k < 3; k++) begin
            fault[0] = 4;
            mask[0]  = 16'($urandom_range(1, 255));
            run_sweep(0, $sformatf("mask_%02h", mask[0][7:0]), -1, -1);
        end
        fault[0] = 0;
    endtask

    task automatic test_saturation();
        fault[1] = 1;
        run_sweep(1, "sat_errw2", -1, -1);
    endtask

    task automatic test_nand4();
        fault[2] = 2;
        run_sweep(2, "nand4_stuck1", -1, -1);
        fault[2] = 0;
        run_sweep(2, "nand4_ideal", -1, -1);
    endtask

    initial begin
        test_reset();
        test_ideal_sweep();
        test_stuck_at_0();
        test_back_to_back();
        test_reset_mid_sweep();
        test_start_ignored();
        test_random_faults();
        test_saturation();
        test_nand4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
